// File: rtl/i2c_pkg.sv
// Shared types and default constants for the I2C SCL/data-phase generator.
package i2c_pkg;

  typedef enum logic [1:0] {
    PH_LOW_A  = 2'd0,
    PH_LOW_B  = 2'd1,
    PH_HIGH_A = 2'd2,
    PH_HIGH_B = 2'd3
  } phase_t;

  localparam int unsigned DEF_DIVIDER = 5000;
  localparam int unsigned DEF_CBITS   = 15;
  localparam int unsigned DEF_TIMEOUT = 65535;
  localparam int unsigned DEF_TBITS   = 16;

endpackage

// File: rtl/i2c_stretch_timer.sv
// Bounds a slave clock stretch: after TIMEOUT consecutive hold cycles it forces
// SCL release for the rest of HIGH_A and raises a sticky timeout flag.
module i2c_stretch_timer
  import i2c_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned TBITS   = DEF_TBITS
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic phase_is_high_a,
  output logic force_rel,
  output logic timeout
);

  localparam logic [TBITS-1:0] TIMER_LAST = TBITS'(TIMEOUT - 1);

  logic [TBITS-1:0] timer;

  // force_rel masks hold, so the timer is cleared on the cycle after it fires
  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= '0;
      force_rel <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (hold) begin
        timer <= timer + TBITS'(1);
        if (timer == TIMER_LAST) begin
          force_rel <= 1'b1;
          timeout   <= 1'b1;
        end
      end else begin
        timer <= '0;
      end
      if (!phase_is_high_a) force_rel <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_scl_stretch_gen.sv
// I2C master SCL quarter-phase generator with slave clock-stretch support.
// Optional stretch timeout enabled by defining I2C_STRETCH_TIMEOUT_EN.
module i2c_scl_stretch_gen
  import i2c_pkg::*;
#(
  parameter int unsigned DIVIDER = DEF_DIVIDER,
  parameter int unsigned CBITS   = DEF_CBITS,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned TBITS   = DEF_TBITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       scl_in,
  output logic       scl_oe,
  output logic       data_clk,
  output logic [1:0] phase,
  output logic       switch_range,
  output logic       stretching,
  output logic       timeout
);

  localparam logic [CBITS-1:0] CNT_LAST = CBITS'(4 * DIVIDER - 1);
  localparam logic [CBITS-1:0] Q1_START = CBITS'(DIVIDER);
  localparam logic [CBITS-1:0] Q2_START = CBITS'(2 * DIVIDER);
  localparam logic [CBITS-1:0] Q3_START = CBITS'(3 * DIVIDER);

  logic             scl_meta;
  logic             scl_s;
  logic [CBITS-1:0] cnt;
  logic [CBITS-1:0] cnt_nxt;
  phase_t           phase_nxt;
  logic             hold;
  logic             force_rel;
  logic             phase_is_high_a;

  assign phase_is_high_a = (phase == PH_HIGH_A);

  // A slave may only stretch once the master has released SCL (HIGH_A)
  assign hold = phase_is_high_a && ena && !scl_s && !force_rel;

  // Next count and its quarter decode
  always_comb begin
    cnt_nxt   = cnt;
    phase_nxt = PH_LOW_A;
    if (!hold) begin
      cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CBITS'(1);
    end
    if (cnt_nxt < Q1_START)      phase_nxt = PH_LOW_A;
    else if (cnt_nxt < Q2_START) phase_nxt = PH_LOW_B;
    else if (cnt_nxt < Q3_START) phase_nxt = PH_HIGH_A;
    else                         phase_nxt = PH_HIGH_B;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta     <= 1'b1;
      scl_s        <= 1'b1;
      cnt          <= '0;
      phase        <= 2'(PH_LOW_A);
      data_clk     <= 1'b0;
      scl_oe       <= 1'b0;
      switch_range <= 1'b0;
      stretching   <= 1'b0;
    end else begin
      scl_meta     <= scl_in;
      scl_s        <= scl_meta;
      cnt          <= cnt_nxt;
      phase        <= 2'(phase_nxt);
      data_clk     <= (phase_nxt == PH_LOW_B) || (phase_nxt == PH_HIGH_A);
      scl_oe       <= ena && ((phase_nxt == PH_LOW_A) || (phase_nxt == PH_LOW_B));
      switch_range <= (phase_nxt == PH_HIGH_A);
      stretching   <= hold;
    end
  end

`ifdef I2C_STRETCH_TIMEOUT_EN
  i2c_stretch_timer #(
    .TIMEOUT (TIMEOUT),
    .TBITS   (TBITS)
  ) u_timer (
    .clk             (clk),
    .rst             (rst),
    .hold            (hold),
    .phase_is_high_a (phase_is_high_a),
    .force_rel       (force_rel),
    .timeout         (timeout)
  );
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_scl_stretch_gen.sv
// Directed bench for i2c_scl_stretch_gen: a free-running vector table followed by
// stretch, timeout, ena-drop and reset-during-stretch sequences.
module tb_i2c_scl_stretch_gen;
  localparam int unsigned DIVIDER = 4;
  localparam int unsigned CBITS   = 5;
  localparam int unsigned TIMEOUT = 10;
  localparam int unsigned TBITS   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       scl_in;
  logic       scl_oe;
  logic       data_clk;
  logic [1:0] phase;
  logic       switch_range;
  logic       stretching;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       ena;
    logic       scl;
    logic [1:0] ph;
    logic       oe;
    logic       dclk;
    logic       sw;
    logic       str;
    logic       to;
  } vec_t;

  vec_t vecs[32];

  i2c_scl_stretch_gen #(
    .DIVIDER (DIVIDER),
    .CBITS   (CBITS),
    .TIMEOUT (TIMEOUT),
    .TBITS   (TBITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .scl_in       (scl_in),
    .scl_oe       (scl_oe),
    .data_clk     (data_clk),
    .phase        (phase),
    .switch_range (switch_range),
    .stretching   (stretching),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic s, input logic [1:0] p, input logic o,
                              input logic d, input logic w, input logic st, input logic t);
    vec_t v;
    v = '{ena: e, scl: s, ph: p, oe: o, dclk: d, sw: w, str: st, to: t};
    return v;
  endfunction

  task automatic fill(input int first, input int n, input vec_t v);
    for (int i = first; i < first + n; i++) vecs[i] = v;
  endtask

  // Leaves cnt at 6 (two edges into LOW_B) with SCL released by the slave
  task automatic sync_to_cnt6();
    logic [1:0] prev;
    logic       found;
    found  = 1'b0;
    scl_in = 1'b1;
    prev   = phase;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (phase == 2'd1 && prev == 2'd0) found = 1'b1;
      prev = phase;
    end
    chk("sync_to_low_b", 8'(found), 8'd1);
    step();
    step();
  endtask

  task automatic count_to_high_b(input string name, input int exp_steps);
    int n;
    n = 0;
    while (phase != 2'd3 && n < 40) begin
      step();
      n++;
    end
    chk(name, 8'(n), 8'(exp_steps));
  endtask

  initial begin
    // Table: ena=1 with SCL released, then ena=0 with SCL held low by another master
    fill(0, 3,  mk(1, 1, 2'd0, 1, 0, 0, 0, 0));
    fill(3, 4,  mk(1, 1, 2'd1, 1, 1, 0, 0, 0));
    fill(7, 4,  mk(1, 1, 2'd2, 0, 1, 1, 0, 0));
    fill(11, 4, mk(1, 1, 2'd3, 0, 0, 0, 0, 0));
    fill(15, 1, mk(1, 1, 2'd0, 1, 0, 0, 0, 0));
    fill(16, 3, mk(0, 0, 2'd0, 0, 0, 0, 0, 0));
    fill(19, 4, mk(0, 0, 2'd1, 0, 1, 0, 0, 0));
    fill(23, 4, mk(0, 0, 2'd2, 0, 1, 1, 0, 0));
    fill(27, 4, mk(0, 0, 2'd3, 0, 0, 0, 0, 0));
    fill(31, 1, mk(0, 0, 2'd0, 0, 0, 0, 0, 0));

    rst    = 1'b1;
    ena    = 1'b0;
    scl_in = 1'b1;
    step();
    step();
    chk("reset_state", {1'b0, phase, scl_oe, data_clk, switch_range, stretching, timeout}, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      ena    = vecs[i].ena;
      scl_in = vecs[i].scl;
      step();
      chk($sformatf("vec%0d", i),
          {1'b0, phase, scl_oe, data_clk, switch_range, stretching, timeout},
          {1'b0, vecs[i].ph, vecs[i].oe, vecs[i].dclk, vecs[i].sw, vecs[i].str, vecs[i].to});
    end

    // Stretch of 8 cycles at HIGH_A entry, released 3 edges after scl_in rises
    ena = 1'b1;
    sync_to_cnt6();
    scl_in = 1'b0;
    step();
    chk("t2_low_b_no_stretch", {5'd0, phase, stretching}, {5'd0, 2'd1, 1'b0});
    step();
    chk("t2_enter_high_a", {5'd0, phase, stretching}, {5'd0, 2'd2, 1'b0});
    for (int i = 0; i < 8; i++) begin
      if (i == 6) scl_in = 1'b1;
      step();
      chk($sformatf("t2_hold%0d", i), {5'd0, phase, stretching}, {5'd0, 2'd2, 1'b1});
    end
    step();
    chk("t2_release", {5'd0, phase, stretching}, {5'd0, 2'd2, 1'b0});
    count_to_high_b("t2_resume_at_9", 3);

    // SCL stuck low: bounded only when the timeout feature is built in
    sync_to_cnt6();
    scl_in = 1'b0;
    step();
    step();
    for (int i = 1; i <= 10; i++) begin
      step();
`ifdef I2C_STRETCH_TIMEOUT_EN
      chk($sformatf("t3_hold%0d", i), {6'd0, stretching, timeout}, {6'd0, 1'b1, (i == 10)});
`else
      chk($sformatf("t3_hold%0d", i), {6'd0, stretching, timeout}, {6'd0, 1'b1, 1'b0});
`endif
    end
`ifdef I2C_STRETCH_TIMEOUT_EN
    step();
    chk("t3_forced_release", {4'd0, phase, stretching, timeout}, {4'd0, 2'd2, 1'b0, 1'b1});
    count_to_high_b("t3_resume_at_9", 3);
    for (int i = 0; i < 20; i++) step();
    chk("t3_timeout_sticky", 8'(timeout), 8'd1);
`else
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t3_frozen%0d", i), {5'd0, phase, stretching}, {5'd0, 2'd2, 1'b1});
    end
    scl_in = 1'b1;
    step();
    step();
    step();
    chk("t3_release", {5'd0, phase, stretching}, {5'd0, 2'd2, 1'b0});
    count_to_high_b("t3_resume_at_9", 3);
`endif

    // Dropping ena mid-stretch releases the counter on the next edge
    ena = 1'b1;
    sync_to_cnt6();
    scl_in = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_hold%0d", i), 8'(stretching), 8'd1);
    end
    ena = 1'b0;
    step();
    chk("t6_ena_drop", {4'd0, phase, stretching, scl_oe}, {4'd0, 2'd2, 1'b0, 1'b0});
    count_to_high_b("t6_resume_at_9", 3);

    // Reset during a stretch clears everything, then counting restarts from 0
    ena = 1'b1;
    sync_to_cnt6();
    scl_in = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t5_hold%0d", i), 8'(stretching), 8'd1);
    end
`ifdef I2C_STRETCH_TIMEOUT_EN
    chk("t5_timeout_before_rst", 8'(timeout), 8'd1);
`endif
    rst = 1'b1;
    step();
    chk("t5_reset_mid_stretch", {1'b0, phase, scl_oe, data_clk, switch_range, stretching, timeout}, 8'h00);
    rst    = 1'b0;
    scl_in = 1'b1;
    step();
    step();
    step();
    chk("t5_cnt3_low_a", {5'd0, phase, scl_oe}, {5'd0, 2'd0, 1'b1});
    step();
    chk("t5_cnt4_low_b", {5'd0, phase, data_clk}, {5'd0, 2'd1, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
